// File: rtl/lc3_control_fsm_pkg.sv
// Shared definitions for the LC-3 control stage: state encoding, opcodes, mux/ALU codes
// and the small decode helpers used by the top and the condition-code register.
package lc3_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_MEM_WAIT = 3'd1,
    S_LOAD_IR  = 3'd2,
    S_DECODE   = 3'd3,
    S_EXECUTE  = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [1:0] SR1MUX_DFLT  = 2'b00;
  localparam logic [1:0] SR1MUX_IR8_6 = 2'b01;
  localparam logic [1:0] DRMUX_IR11_9 = 2'b00;

  localparam logic [2:0] NZP_RESET = 3'b010;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      OP_ADD, OP_AND, OP_NOT: op_supported = 1'b1;
      default:                op_supported = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] aluk_for(input logic [3:0] op);
    case (op)
      OP_ADD:  aluk_for = ALUK_ADD;
      OP_AND:  aluk_for = ALUK_AND;
      OP_NOT:  aluk_for = ALUK_NOT;
      default: aluk_for = ALUK_PASSA;
    endcase
  endfunction

  // Exactly one of N/Z/P is ever set.
  function automatic logic [2:0] nzp_of(input logic [15:0] value);
    if (value[15]) begin
      nzp_of = 3'b100;
    end else if (value == 16'h0000) begin
      nzp_of = 3'b010;
    end else begin
      nzp_of = 3'b001;
    end
  endfunction

endpackage

// File: rtl/lc3_cc_reg.sv
// NZP condition-code register: classifies the bus value and captures it when ld is high.
module lc3_cc_reg
  import lc3_control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic [15:0] bus,
  output logic [2:0]  nzp
);

  // Condition codes hold their value except during the execute cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzp <= NZP_RESET;
    end else if (ld) begin
      nzp <= nzp_of(bus);
    end else begin
      nzp <= nzp;
    end
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 fetch/decode/execute control for operate instructions; owns PC, IR and NZP.
// Optional build macro CTRL_SINGLE_STEP_EN adds i_STEP, which gates leaving DECODE.
module lc3_control_fsm
  import lc3_control_fsm_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h3000,
  parameter int          WIDTH    = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic [WIDTH-1:0] i_bus,
  input  logic             i_MEM_R,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             i_STEP,
`endif
  output logic             o_MEM_EN,
  output logic             o_LD_MAR,
  output logic             o_LD_MDR,
  output logic             o_GATE_PC,
  output logic             o_GATE_MDR,
  output logic             o_GATE_ALU,
  output logic             o_LD_REG,
  output logic [1:0]       o_ALUK,
  output logic [1:0]       o_SR1MUX,
  output logic [1:0]       o_DRMUX,
  output logic [WIDTH-1:0] o_IR,
  output logic [WIDTH-1:0] o_PC,
  output logic [2:0]       o_NZP,
  output logic             o_ILLEGAL
);

  state_t           state;
  state_t           next_state;
  logic             step_ok;
  logic             op_ok;
  logic [3:0]       opcode;

`ifdef CTRL_SINGLE_STEP_EN
  assign step_ok = i_STEP;
`else
  assign step_ok = 1'b1;
`endif

  assign opcode = o_IR[15:12];
  assign op_ok  = op_supported(opcode);

  // Next-state selection; i_MEM_R only matters while waiting on memory.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = S_MEM_WAIT;
      S_MEM_WAIT: next_state = i_MEM_R ? S_LOAD_IR : S_MEM_WAIT;
      S_LOAD_IR:  next_state = S_DECODE;
      S_DECODE: begin
        if (!step_ok) begin
          next_state = S_DECODE;
        end else if (op_ok) begin
          next_state = S_EXECUTE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_EXECUTE:  next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // State, PC and IR registers.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state <= S_FETCH;
      o_PC  <= PC_RESET;
      o_IR  <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH) begin
        o_PC <= o_PC + WIDTH'(1);
      end else begin
        o_PC <= o_PC;
      end
      if (state == S_LOAD_IR) begin
        o_IR <= i_bus;
      end else begin
        o_IR <= o_IR;
      end
    end
  end

  // Outputs depend only on flops (plus LD_MDR on the ready handshake), so they
  // are stable through the falling edge; reset forces every strobe low at once.
  always_comb begin
    o_MEM_EN   = 1'b0;
    o_LD_MAR   = 1'b0;
    o_LD_MDR   = 1'b0;
    o_GATE_PC  = 1'b0;
    o_GATE_MDR = 1'b0;
    o_GATE_ALU = 1'b0;
    o_LD_REG   = 1'b0;
    o_ALUK     = ALUK_PASSA;
    o_SR1MUX   = SR1MUX_DFLT;
    o_DRMUX    = DRMUX_IR11_9;
    o_ILLEGAL  = 1'b0;
    if (!i_RST_N) begin
      o_MEM_EN = 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          o_GATE_PC = 1'b1;
          o_LD_MAR  = 1'b1;
        end
        S_MEM_WAIT: begin
          o_MEM_EN = 1'b1;
          o_LD_MDR = i_MEM_R;
        end
        S_LOAD_IR:  o_GATE_MDR = 1'b1;
        S_DECODE:   o_ILLEGAL  = ~op_ok & step_ok;
        S_EXECUTE: begin
          o_GATE_ALU = 1'b1;
          o_LD_REG   = 1'b1;
          o_SR1MUX   = SR1MUX_IR8_6;
          o_DRMUX    = DRMUX_IR11_9;
          o_ALUK     = aluk_for(opcode);
        end
        default:    o_MEM_EN = 1'b0;
      endcase
    end
  end

  lc3_cc_reg u_cc_reg (
    .clk   (i_CLK),
    .rst_n (i_RST_N),
    .ld    (state == S_EXECUTE),
    .bus   (i_bus[15:0]),
    .nzp   (o_NZP)
  );

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed scoreboard bench for lc3_control_fsm; a second instance covers PC wrap from 16'hFFFF.
module tb_lc3_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus;
  logic        mem_r;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif

  logic        mem_en, ld_mar, ld_mdr, gate_pc, gate_mdr, gate_alu, ld_reg, illegal;
  logic [1:0]  aluk, sr1mux, drmux;
  logic [15:0] ir, pc;
  logic [2:0]  nzp;

  logic        w_mem_en, w_ld_mar, w_ld_mdr, w_gate_pc, w_gate_mdr, w_gate_alu, w_ld_reg, w_illegal;
  logic [1:0]  w_aluk, w_sr1mux, w_drmux;
  logic [15:0] w_ir, w_pc;
  logic [2:0]  w_nzp;

  always #5 clk = ~clk;

  lc3_control_fsm dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_bus(bus), .i_MEM_R(mem_r),
`ifdef CTRL_SINGLE_STEP_EN
    .i_STEP(step),
`endif
    .o_MEM_EN(mem_en), .o_LD_MAR(ld_mar), .o_LD_MDR(ld_mdr), .o_GATE_PC(gate_pc),
    .o_GATE_MDR(gate_mdr), .o_GATE_ALU(gate_alu), .o_LD_REG(ld_reg), .o_ALUK(aluk),
    .o_SR1MUX(sr1mux), .o_DRMUX(drmux), .o_IR(ir), .o_PC(pc), .o_NZP(nzp), .o_ILLEGAL(illegal)
  );

  lc3_control_fsm #(.PC_RESET(16'hFFFF)) dut_wrap (
    .i_CLK(clk), .i_RST_N(rst_n), .i_bus(bus), .i_MEM_R(mem_r),
`ifdef CTRL_SINGLE_STEP_EN
    .i_STEP(step),
`endif
    .o_MEM_EN(w_mem_en), .o_LD_MAR(w_ld_mar), .o_LD_MDR(w_ld_mdr), .o_GATE_PC(w_gate_pc),
    .o_GATE_MDR(w_gate_mdr), .o_GATE_ALU(w_gate_alu), .o_LD_REG(w_ld_reg), .o_ALUK(w_aluk),
    .o_SR1MUX(w_sr1mux), .o_DRMUX(w_drmux), .o_IR(w_ir), .o_PC(w_pc), .o_NZP(w_nzp),
    .o_ILLEGAL(w_illegal)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic [2:0]  m_nzp;

  // Control vector: {MEM_EN,LD_MAR,LD_MDR,GATE_PC,GATE_MDR,GATE_ALU,LD_REG,ALUK,SR1MUX,DRMUX,ILLEGAL}
  function automatic logic [13:0] mk(input logic me, input logic lmar, input logic lmdr,
                                     input logic gpc, input logic gmdr, input logic galu,
                                     input logic lreg, input logic [1:0] k, input logic [1:0] s1,
                                     input logic [1:0] d, input logic ill);
    return {me, lmar, lmdr, gpc, gmdr, galu, lreg, k, s1, d, ill};
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return {18'd0, mem_en, ld_mar, ld_mdr, gate_pc, gate_mdr, gate_alu, ld_reg,
                       aluk, sr1mux, drmux, illegal};
      1:       return {16'd0, pc};
      2:       return {16'd0, ir};
      3:       return {29'd0, nzp};
      4:       return {16'd0, w_pc};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [2:0] exp_nzp(input logic [15:0] v);
    if (v[15])              return 3'b100;
    else if (v == 16'd0)    return 3'b010;
    else                    return 3'b001;
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t        x;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      obs = observe(x.sel);
      checks++;
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from the FETCH cycle; the caller is just past a rising edge in FETCH.
  task automatic run_instr(input logic [15:0] instr, input int nwait, input logic [15:0] exec_bus);
    logic       legal;
    logic [1:0] k;
    case (instr[15:12])
      4'b0001: begin legal = 1'b1; k = 2'b00; end
      4'b0101: begin legal = 1'b1; k = 2'b01; end
      4'b1001: begin legal = 1'b1; k = 2'b10; end
      default: begin legal = 1'b0; k = 2'b11; end
    endcase
    mem_r = 1'b0; bus = 16'hDEAD;
    push("fetch_ctrl", 0, 32'(mk(0,1,0,1,0,0,0,2'b11,2'b00,2'b00,0)));
    push("fetch_pc", 1, 32'(m_pc));
    next_cycle();
    m_pc = m_pc + 16'd1;
    for (int w = 0; w < nwait; w++) begin
      push("wait_ctrl", 0, 32'(mk(1,0,0,0,0,0,0,2'b11,2'b00,2'b00,0)));
      push("wait_pc", 1, 32'(m_pc));
      push("wait_ir", 2, 32'(m_ir));
      next_cycle();
    end
    mem_r = 1'b1;
    push("ready_ctrl", 0, 32'(mk(1,0,1,0,0,0,0,2'b11,2'b00,2'b00,0)));
    push("ready_ir", 2, 32'(m_ir));
    next_cycle();
    bus = instr;
    push("load_ctrl", 0, 32'(mk(0,0,0,0,1,0,0,2'b11,2'b00,2'b00,0)));
    push("load_ir_old", 2, 32'(m_ir));
    next_cycle();
    m_ir = instr; mem_r = 1'b0; bus = 16'hDEAD;
    push("decode_ctrl", 0, 32'(mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,~legal)));
    push("decode_ir", 2, 32'(m_ir));
    next_cycle();
    if (!legal) begin
      push("illegal_nzp_kept", 3, 32'(m_nzp));
      drain();
    end else begin
      bus = exec_bus;
      push("exec_ctrl", 0, 32'(mk(0,0,0,0,0,1,1,k,2'b01,2'b00,0)));
      push("exec_nzp_old", 3, 32'(m_nzp));
      next_cycle();
      m_nzp = exp_nzp(exec_bus);
      push("exec_nzp_new", 3, 32'(m_nzp));
      drain();
      bus = 16'hDEAD;
    end
  endtask

  task automatic do_reset_model();
    m_pc = 16'h3000; m_ir = 16'h0000; m_nzp = 3'b010;
  endtask

  initial begin
    rst_n = 1'b0; mem_r = 1'b0; bus = 16'h0000;
    do_reset_model();
    #12;
    push("rst_ctrl", 0, 32'(mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0)));
    push("rst_pc", 1, 32'(m_pc));
    push("rst_ir", 2, 32'(m_ir));
    push("rst_nzp", 3, 32'(m_nzp));
    push("rst_wrap_pc", 4, 32'h0000_FFFF);
    drain();
    @(posedge clk); #1; rst_n = 1'b1;

    run_instr(16'h1642, 0, 16'h8000);
    push("wrap_pc", 4, 32'h0000_0000);
    drain();
    run_instr(16'h5A85, 3, 16'h0000);
    run_instr(16'h967F, 0, 16'h0007);
    run_instr(16'hF025, 1, 16'h0000);
    run_instr(16'h1242, 0, 16'h8123);
    run_instr(16'h3000, 0, 16'h0000);
    run_instr(16'h1000, 2, 16'h1234);

    // Reset in the middle of a memory wait drops the request immediately.
    mem_r = 1'b0;
    push("pre_rst_fetch", 0, 32'(mk(0,1,0,1,0,0,0,2'b11,2'b00,2'b00,0)));
    next_cycle();
    push("pre_rst_wait", 0, 32'(mk(1,0,0,0,0,0,0,2'b11,2'b00,2'b00,0)));
    drain();
    #2 rst_n = 1'b0;
    #1;
    do_reset_model();
    push("midrst_ctrl", 0, 32'(mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0)));
    push("midrst_pc", 1, 32'(m_pc));
    push("midrst_ir", 2, 32'(m_ir));
    push("midrst_nzp", 3, 32'(m_nzp));
    push("midrst_wrap_pc", 4, 32'h0000_FFFF);
    drain();
    @(posedge clk); #1; rst_n = 1'b1;
    run_instr(16'h1642, 0, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
